alu_issue_stage: RTL and testbench

//  Requester-side end of the ALU interface: accepts operation requests over valid/ready,

---
 rtl/alu_issue_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: requester-side end of the ALU interface in the execute stage.
// Registers one request (operands, op, tag) toward a combinational ALU, and on the
// following edge captures the ALU result and zero flag into an in-order response FIFO.

package alu_issue_pkg;
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } aluOperation_t;
endpackage

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int  DATA_WIDTH_POW = 6,
    parameter int  TAG_WIDTH      = 5,
    parameter int  RSP_DEPTH      = 4,
    localparam int DATA_WIDTH     = 1 << DATA_WIDTH_POW,
    localparam int PTR_W          = $clog2(RSP_DEPTH),
    localparam int CNT_W          = PTR_W + 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [DATA_WIDTH-1:0] req_operand1_in,
    input  logic [DATA_WIDTH-1:0] req_operand2_in,
    input  aluOperation_t         req_aluOp_in,
    input  logic [TAG_WIDTH-1:0]  req_tag_in,
    output logic [DATA_WIDTH-1:0] alu_operand1_out,
    output logic [DATA_WIDTH-1:0] alu_operand2_out,
    output aluOperation_t         alu_aluOp_out,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic                  alu_zeroFlag_in,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic [DATA_WIDTH-1:0] rsp_result_out,
    output logic                  rsp_zero_out,
    output logic [TAG_WIDTH-1:0]  rsp_tag_out,
    output logic [CNT_W-1:0]      rsp_count_out,
    output logic                  zero_err_out
);

    // Issue register (S1) state
    logic                  iss_valid_q, iss_valid_d;
    logic [DATA_WIDTH-1:0] operand1_q, operand1_d;
    logic [DATA_WIDTH-1:0] operand2_q, operand2_d;
    aluOperation_t         aluop_q, aluop_d;
    logic [TAG_WIDTH-1:0]  iss_tag_q, iss_tag_d;

    // Response FIFO state
    logic [DATA_WIDTH-1:0] fifo_result_q [RSP_DEPTH];
    logic                  fifo_zero_q   [RSP_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag_q    [RSP_DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  zero_err_q, zero_err_d;

    // Handshake terms
    logic fifo_full;
    logic fifo_nonempty;
    logic push;
    logic pop;
    logic accept;
    logic zero_mismatch;

    assign fifo_full     = (count_q == CNT_W'(RSP_DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty & rsp_ready_in;
    // A full FIFO still takes the S1 entry when the head leaves in the same cycle.
    assign push          = iss_valid_q & (~fifo_full | pop);
    assign req_ready_out = ~iss_valid_q | push;
    assign accept        = req_valid_in & req_ready_out;
    assign zero_mismatch = alu_zeroFlag_in != (alu_result_in == '0);

    assign alu_operand1_out = operand1_q;
    assign alu_operand2_out = operand2_q;
    assign alu_aluOp_out    = aluop_q;

    assign rsp_valid_out  = fifo_nonempty;
    assign rsp_result_out = fifo_result_q[rptr_q];
    assign rsp_zero_out   = fifo_zero_q[rptr_q];
    assign rsp_tag_out    = fifo_tag_q[rptr_q];
    assign rsp_count_out  = count_q;
    assign zero_err_out   = zero_err_q;

    // Next-state for the issue register, FIFO pointers, occupancy and sticky error.
    always_comb begin
        iss_valid_d = iss_valid_q;
        operand1_d  = operand1_q;
        operand2_d  = operand2_q;
        aluop_d     = aluop_q;
        iss_tag_d   = iss_tag_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        zero_err_d  = zero_err_q;

        if (accept) begin
            iss_valid_d = 1'b1;
            operand1_d  = req_operand1_in;
            operand2_d  = req_operand2_in;
            aluop_d     = req_aluOp_in;
            iss_tag_d   = req_tag_in;
        end else if (push) begin
            // Operands stay on the ALU bus; only the valid bit drops.
            iss_valid_d = 1'b0;
        end

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && zero_mismatch) begin
            zero_err_d = 1'b1;
        end
    end

    // Control and issue registers; reset empties the pipeline and the FIFO.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            iss_valid_q <= 1'b0;
            operand1_q  <= '0;
            operand2_q  <= '0;
            aluop_q     <= OP_ADD;
            iss_tag_q   <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            zero_err_q  <= 1'b0;
        end else begin
            iss_valid_q <= iss_valid_d;
            operand1_q  <= operand1_d;
            operand2_q  <= operand2_d;
            aluop_q     <= aluop_d;
            iss_tag_q   <= iss_tag_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            zero_err_q  <= zero_err_d;
        end
    end

    // FIFO storage: ALU result and flag are captured verbatim alongside the S1 tag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_result_q[i] <= '0;
                fifo_zero_q[i]   <= 1'b0;
                fifo_tag_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_result_q[wptr_q] <= alu_result_in;
            fifo_zero_q[wptr_q]   <= alu_zeroFlag_in;
            fifo_tag_q[wptr_q]    <= iss_tag_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU attached.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    localparam int DW    = 64;
    localparam int TW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic                clk = 1'b0;
    logic                rst_in = 1'b1;
    logic                req_valid_in = 1'b0;
    logic                req_ready_out;
    logic [DW-1:0]       req_operand1_in = '0;
    logic [DW-1:0]       req_operand2_in = '0;
    aluOperation_t       req_aluOp_in = OP_ADD;
    logic [TW-1:0]       req_tag_in = '0;
    logic [DW-1:0]       alu_operand1_out;
    logic [DW-1:0]       alu_operand2_out;
    aluOperation_t       alu_aluOp_out;
    logic [DW-1:0]       alu_result_in;
    logic                alu_zeroFlag_in;
    logic                rsp_valid_out;
    logic                rsp_ready_in = 1'b1;
    logic [DW-1:0]       rsp_result_out;
    logic                rsp_zero_out;
    logic [TW-1:0]       rsp_tag_out;
    logic [CW-1:0]       rsp_count_out;
    logic                zero_err_out;

    logic                bad_zero = 1'b0;

    typedef struct {
        logic [DW-1:0] res;
        logic          z;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t expq[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_issue_stage dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_ready_out    (req_ready_out),
        .req_operand1_in  (req_operand1_in),
        .req_operand2_in  (req_operand2_in),
        .req_aluOp_in     (req_aluOp_in),
        .req_tag_in       (req_tag_in),
        .alu_operand1_out (alu_operand1_out),
        .alu_operand2_out (alu_operand2_out),
        .alu_aluOp_out    (alu_aluOp_out),
        .alu_result_in    (alu_result_in),
        .alu_zeroFlag_in  (alu_zeroFlag_in),
        .rsp_valid_out    (rsp_valid_out),
        .rsp_ready_in     (rsp_ready_in),
        .rsp_result_out   (rsp_result_out),
        .rsp_zero_out     (rsp_zero_out),
        .rsp_tag_out      (rsp_tag_out),
        .rsp_count_out    (rsp_count_out),
        .zero_err_out     (zero_err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_alu(input aluOperation_t op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

    // Combinational ALU driven by the DUT's registered operands.
    assign alu_result_in   = ref_alu(alu_aluOp_out, alu_operand1_out, alu_operand2_out);
    assign alu_zeroFlag_in = bad_zero ? 1'b0 : (alu_result_in == '0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic note_fail(input string name, input string detail);
        total_cnt++;
        $display("FAIL %s: %s (t=%0t)", name, detail, $time);
    endtask

    // Present one request, hold it until accepted, and queue the expected response.
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input aluOperation_t op,
                         input logic [TW-1:0] tag, output int stalls, output int cnt_seen);
        exp_t e;
        stalls   = 0;
        cnt_seen = 0;
        req_operand1_in = a;
        req_operand2_in = b;
        req_aluOp_in    = op;
        req_tag_in      = tag;
        req_valid_in    = 1'b1;
        forever begin
            @(negedge clk);
            if (req_ready_out) break;
            stalls++;
            if (stalls > 300) begin
                note_fail("issue_timeout", $sformatf("got no accept for tag %0d, required accept", tag));
                req_valid_in = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        cnt_seen = int'(rsp_count_out);
        e.res = ref_alu(op, a, b);
        e.z   = bad_zero ? 1'b0 : (e.res == '0);
        e.tag = tag;
        expq.push_back(e);
        @(posedge clk);
        #1;
        req_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready_in = 1'b1;
        while ((expq.size() != 0 || rsp_valid_out) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", 64'(expq.size()), 64'd0);
        chk("drain_rsp_valid", 64'(rsp_valid_out), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tagname);
        chk({tagname, "_rsp_valid"}, 64'(rsp_valid_out), 64'd0);
        chk({tagname, "_count"}, 64'(rsp_count_out), 64'd0);
        chk({tagname, "_req_ready"}, 64'(req_ready_out), 64'd1);
        chk({tagname, "_aluop"}, 64'(alu_aluOp_out), 64'(OP_ADD));
        chk({tagname, "_zero_err"}, 64'(zero_err_out), 64'd0);
        chk({tagname, "_rsp_result"}, 64'(rsp_result_out), 64'd0);
        chk({tagname, "_alu_op1"}, 64'(alu_operand1_out), 64'd0);
    endtask

    // Response monitor: every handshake on the response side is checked against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_in && rsp_valid_out && rsp_ready_in) begin
                if (expq.size() == 0) begin
                    note_fail("unexpected_rsp", $sformatf("got tag %0d result %0h, required no response",
                                                          rsp_tag_out, rsp_result_out));
                end else begin
                    e = expq.pop_front();
                    chk("rsp_result", 64'(rsp_result_out), 64'(e.res));
                    chk("rsp_zero", 64'(rsp_zero_out), 64'(e.z));
                    chk("rsp_tag", 64'(rsp_tag_out), 64'(e.tag));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int cn;
        logic [DW-1:0] ra, rb;
        bit done;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        @(negedge clk);
        check_reset_state("por");

        // Single ADD and its latency
        @(posedge clk);
        #1;
        issue(64'd5, 64'd7, OP_ADD, 5'd3, st, cn);
        @(negedge clk);
        chk("t2_alu_op1", 64'(alu_operand1_out), 64'd5);
        chk("t2_alu_op2", 64'(alu_operand2_out), 64'd7);
        chk("t2_alu_op", 64'(alu_aluOp_out), 64'(OP_ADD));
        chk("t2_rsp_not_yet", 64'(rsp_valid_out), 64'd0);
        @(negedge clk);
        chk("t2_rsp_valid", 64'(rsp_valid_out), 64'd1);
        chk("t2_rsp_result", 64'(rsp_result_out), 64'd12);
        chk("t2_rsp_tag", 64'(rsp_tag_out), 64'd3);
        @(posedge clk);
        #1;
        drain();

        // Back-to-back SUB/AND/OR with the consumer always ready
        issue(64'd9, 64'd9, OP_SUB, 5'd10, st, cn);
        chk("t3_stall_sub", 64'(st), 64'd0);
        issue(64'hF0, 64'h0F, OP_AND, 5'd11, st, cn);
        chk("t3_stall_and", 64'(st), 64'd0);
        issue(64'h1, 64'h2, OP_OR, 5'd12, st, cn);
        chk("t3_stall_or", 64'(st), 64'd0);
        @(negedge clk);
        chk("t3_second_valid", 64'(rsp_valid_out), 64'd1);
        chk("t3_second_tag", 64'(rsp_tag_out), 64'd11);
        @(negedge clk);
        chk("t3_third_valid", 64'(rsp_valid_out), 64'd1);
        chk("t3_third_result", 64'(rsp_result_out), 64'd3);
        @(negedge clk);
        chk("t3_empty_after", 64'(rsp_valid_out), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: four queued, fifth held in S1, sixth waiting
        rsp_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(64'(100 + i), 64'(i), OP_ADD, 5'(20 + i), st, cn);
            chk("t4_fill_stall", 64'(st), 64'd0);
        end
        req_operand1_in = 64'd200;
        req_operand2_in = 64'd1;
        req_aluOp_in    = OP_SUB;
        req_tag_in      = 5'd25;
        req_valid_in    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_ready_low", 64'(req_ready_out), 64'd0);
            chk("t4_count_full", 64'(rsp_count_out), 64'd4);
            chk("t4_alu_op1_hold", 64'(alu_operand1_out), 64'd104);
            chk("t4_alu_op2_hold", 64'(alu_operand2_out), 64'd4);
            @(posedge clk);
            #1;
        end
        rsp_ready_in = 1'b1;
        issue(64'd200, 64'd1, OP_SUB, 5'd25, st, cn);
        drain();

        // Full FIFO with simultaneous pop and push; pointers wrap several times
        rsp_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) issue(64'(i), 64'(3 * i), OP_OR, 5'(i), st, cn);
        rsp_ready_in = 1'b1;
        for (int i = 5; i < 11; i++) begin
            issue(64'(1000 + i), 64'(7), OP_SUB, 5'(i), st, cn);
            chk("t5_no_stall", 64'(st), 64'd0);
            chk("t5_count_full", 64'(cn), 64'd4);
        end
        drain();

        // Zero flag disagreement sets the sticky error
        chk("t6_err_before", 64'(zero_err_out), 64'd0);
        bad_zero = 1'b1;
        issue(64'd4, 64'd4, OP_SUB, 5'd7, st, cn);
        @(negedge clk);
        chk("t6_err_not_yet", 64'(zero_err_out), 64'd0);
        @(negedge clk);
        chk("t6_err_set", 64'(zero_err_out), 64'd1);
        @(posedge clk);
        #1;
        bad_zero = 1'b0;
        issue(64'd1, 64'd1, OP_ADD, 5'd8, st, cn);
        issue(64'd0, 64'd0, OP_AND, 5'd9, st, cn);
        drain();
        chk("t6_err_sticky", 64'(zero_err_out), 64'd1);

        // Reset mid-stream with three entries queued
        rsp_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) issue(64'(50 + i), 64'd2, OP_ADD, 5'(1 + i), st, cn);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_count_before", 64'(rsp_count_out), 64'd3);
        #2;
        rst_in = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        @(negedge clk);
        check_reset_state("t1");
        rsp_ready_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_no_stale_rsp", 64'(rsp_valid_out), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random consumer backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    ra = {$urandom, $urandom};
                    case ($urandom_range(0, 3))
                        0:       rb = ra;
                        1:       rb = '0;
                        default: rb = {$urandom, $urandom};
                    endcase
                    if ($urandom_range(0, 7) == 0) ra = '0;
                    issue(ra, rb, aluOperation_t'($urandom_range(0, 3)), 5'($urandom), st, cn);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
